sample_streamer: RTL
====================

Name: sample_streamer

Overview:
- Transmit-side source for the moving-average datapath.
- Holds a sample table loaded through a write port.
- On a start pulse, streams `len` samples from address 0 as single-cycle valid strobes, with a programmable number of idle cycles between samples.
- Output pins connect directly to `sliding_window` `in_valid`/`in_sample`. This replaces bench-side ROM driving, so the same stream is available in hardware.

Parameters:
- WIDTH, 32, sample width in bits (signed, two's complement)
- ADDR_W, 12, table address width; depth = 2**ADDR_W (4096)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_we  in  1  table write enable; honoured only when busy=0
- load_addr  in  ADDR_W  table write address
- load_data  in  WIDTH  table write data
- start  in  1  single-cycle start request; honoured only in IDLE
- len  in  ADDR_W+1  sample count, 0..2**ADDR_W; sampled on accepted start
- gap  in  8  idle cycles between samples; sampled on accepted start
- abort  in  1  synchronous stop request
- out_valid  out  1  one-cycle strobe per sample (to `in_valid`)
- out_sample  out  WIDTH  sample data, signed (to `in_sample`)
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses or abort takes effect
- done  out  1  one-cycle pulse after the final sample
- sent_cnt  out  ADDR_W+1  number of samples emitted in the current/last run

Behaviour:

Reset (rst_n low, async):
- State = IDLE.
- out_valid, out_sample, busy, done and sent_cnt all = 0.
- Table contents are not reset.
- A reset mid-stream drops out_valid immediately; no done pulse.

Table:
- Synchronous-read single-port RAM with 1-cycle read latency.
- Writes with load_we=1 and busy=0 land at the clock edge.
- load_we while busy=1 is ignored and the table is unchanged.

State machine: IDLE, FETCH, SEND, GAP, FIN.
- IDLE:
  - start=1 with len>0 at edge T: latch len and gap, clear sent_cnt, issue read of address 0, go to FETCH (cycle T+1, busy=1).
  - start=1 with len=0: go to FIN; done=1 at T+1 with no valid.
- FETCH → SEND. out_sample is registered from RAM, so out_valid=1 with mem[0] occurs at cycle T+2.
- SEND (out_valid=1 for exactly this cycle):
  - sent_cnt increments.
  - If this was sample len-1, go to FIN.
  - Else if gap=0, stay in SEND with the next sample (prefetched during the current SEND).
  - Else go to GAP with a counter loaded to gap.
- GAP: out_valid=0 for exactly `gap` cycles, then SEND. The next address is prefetched so there is no bubble.
- Spacing between consecutive out_valid rising cycles = gap+1 cycles exactly.
- FIN: done=1 and busy=0 for one cycle, then IDLE.

Output holding:
- out_sample holds the last emitted value while out_valid=0.
- It changes only when a new SEND cycle begins.

Abort:
- abort=1 in FETCH, SEND or GAP: next cycle is IDLE with out_valid=0 and busy=0.
- No done pulse; sent_cnt holds its value.
- abort has priority over start.
- abort in IDLE or FIN has no effect.

Start handling:
- start while busy=1 (or in FIN) is ignored; it is not queued.
- len > 2**ADDR_W is impossible by width. len = 2**ADDR_W streams the whole table; the address never wraps.

Arithmetic:
- Address counter is ADDR_W+1 bits and is compared against the latched len.
- Data passes through unmodified; no sign manipulation.

Test Plan:
1. Load [5, -3, 0x7FFFFFFF, 0x80000000] at 0..3; len=4, gap=1, start at T -> out_valid at T+2, T+4, T+6, T+8 with exactly those values; done at T+9; busy high T+1..T+8; sent_cnt=4.
2. Same table, gap=0 -> out_valid continuous T+2..T+5 carrying the 4 values in order; done at T+6.
3. len=0 start -> done at T+1, busy never rises, no out_valid, sent_cnt=0.
4. Attempt a load_we to address 1 and a second start while busy -> stream unaffected; table addr 1 still reads -3 on the next run; exactly 4 valids, one done.
5. gap=3, len=4; assert abort in the cycle after the 2nd valid -> IDLE next cycle, no further valids, no done, sent_cnt=2. Repeat the run and pull rst_n low mid-GAP -> all outputs 0 asynchronously; restart works.
6. Load the 4096-entry sample file, len=4096, gap=1, feed `sliding_window` (WIDTH=32, L=8) -> 4096 valids; the averaged outputs match the golden output file bit-exactly.

Source files
------------

// File: rtl/sample_streamer.sv
// -----------------------------------------------------------------------------
// sample_streamer
//
// Transmit-side sample source for the moving-average datapath. A sample table
// is written through a simple load port. A start pulse then streams `len`
// samples, beginning at address 0, as single-cycle valid strobes. `gap` idle
// cycles separate consecutive samples.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_we     table write enable (ignored while busy)
//   load_addr   table write address
//   load_data   table write data
//   start       start request (accepted only in IDLE)
//   len         number of samples to stream, 0..2**ADDR_W (latched on start)
//   gap         idle cycles between samples (latched on start)
//   abort       stop request while streaming
//   out_valid   one-cycle strobe per emitted sample
//   out_sample  emitted sample; holds its value between strobes
//   busy        streaming in progress
//   done        one-cycle pulse after the final sample
//   sent_cnt    samples emitted in the current/last run
// -----------------------------------------------------------------------------
module sample_streamer #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        gap,
    input  logic              abort,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_sample,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sent_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]  mem [0:DEPTH-1];
    logic [WIDTH-1:0]  rd_data_reg;
    logic [WIDTH-1:0]  out_sample_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   addr_reg;      // index of the next table read to issue
    logic [ADDR_W:0]   sent_cnt_reg;
    logic [ADDR_W:0]   sent_cnt_inc;
    logic [7:0]        gap_reg;
    logic [7:0]        gap_cnt_reg;

    logic              start_accept;
    logic              load_out;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    assign sent_cnt_inc = sent_cnt_reg + 1'b1;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_next = SEND;
            SEND: begin
                if (sent_cnt_inc == len_reg) begin
                    state_next = FIN;
                end else if (gap_reg == 8'd0) begin
                    state_next = SEND;
                end else begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg <= 8'd1) begin
                    state_next = SEND;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state_reg == FETCH || state_reg == SEND || state_reg == GAP)) begin
            state_next = IDLE;
        end
    end

    // The read register always holds the next sample to emit. Every time a
    // SEND cycle begins its value moves to out_sample and the following
    // address is read, so back-to-back SEND cycles see no bubble. The final
    // prefetch is suppressed so the address never runs past len.
    always_comb begin
        start_accept = (state_reg == IDLE) && start && (len != '0);
        load_out     = (state_next == SEND);
        rd_en        = start_accept || (load_out && (addr_reg != len_reg));
        rd_addr      = start_accept ? '0 : addr_reg[ADDR_W-1:0];
    end

    // Sample table: no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            mem[load_addr] <= load_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    // State register and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            gap_reg        <= '0;
            gap_cnt_reg    <= '0;
            addr_reg       <= '0;
            sent_cnt_reg   <= '0;
            out_sample_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && start) begin
                len_reg      <= len;
                gap_reg      <= gap;
                sent_cnt_reg <= '0;
            end else if (state_reg == SEND) begin
                sent_cnt_reg <= sent_cnt_inc;
            end

            if (start_accept) begin
                addr_reg <= {{ADDR_W{1'b0}}, 1'b1};
            end else if (rd_en) begin
                addr_reg <= addr_reg + 1'b1;
            end

            if (state_reg == SEND && state_next == GAP) begin
                gap_cnt_reg <= gap_reg;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 8'd1;
            end

            if (load_out) begin
                out_sample_reg <= rd_data_reg;
            end
        end
    end

    assign out_valid  = (state_reg == SEND);
    assign busy       = (state_reg == FETCH) || (state_reg == SEND) || (state_reg == GAP);
    assign done       = (state_reg == FIN);
    assign sent_cnt   = sent_cnt_reg;
    assign out_sample = out_sample_reg;

endmodule
